hilo_mult_unit: RTL and testbench
=================================

Name: hilo_mult_unit

Overview:
- Multi-cycle signed multiplier with architectural HI/LO registers, sitting in EX beside the single-cycle ALU.
- Consumes the 4-bit ALU control code produced by the ALU controller and executes the MULT, MFHI and MFLO codes (8, 10, 9).
- Ignores all other codes.
- Raises a stall to the hazard unit while a multiply is in flight and an instruction needs the unit.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits held as {HI,LO}.
- CODE_MULT, 4'd8, ALU control code for multiply.
- CODE_MFLO, 4'd9, ALU control code for move-from-LO.
- CODE_MFHI, 4'd10, ALU control code for move-from-HI.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  EX-stage instruction valid.
- alu_ctrl_i  in  4  ALU control code from the ALU controller.
- a_i  in  WIDTH  operand rs (signed).
- b_i  in  WIDTH  operand rt (signed).
- flush_i  in  1  pipeline flush; aborts an in-flight multiply.
- stall_o  out  1  combinational; holds the EX instruction.
- busy_o  out  1  registered; high whenever FSM is not IDLE.
- result_o  out  WIDTH  registered MFHI/MFLO result.
- result_valid_o  out  1  registered; result_o is valid this cycle.
- hi_o  out  WIDTH  current HI register.
- lo_o  out  WIDTH  current LO register.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - FSM goes to IDLE.
  - HI, LO, result_o, internal accumulator, multiplicand, multiplier and counter are all cleared to 0.
  - result_valid_o=0, busy_o=0.
  - An in-flight multiply is discarded.
- Decoded request: req_mult / req_mfhi / req_mflo = valid_i && alu_ctrl_i==CODE_x && !flush_i. All other codes produce no action and never stall.
- stall_o = busy_o && (req_mult || req_mfhi || req_mflo). It is combinational and never depends on stall_o itself.
- FSM states IDLE, RUN, FIX.
- IDLE, req_mult:
  - Latch |a_i| and |b_i| as WIDTH-bit unsigned magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - Latch sign = a_i[MSB]^b_i[MSB].
  - Clear the accumulator, set the counter to WIDTH, go to RUN.
- RUN:
  - Each cycle, one shift-add step on the LSB of the multiplier; the counter decrements.
  - When the counter reaches 1 in RUN, go to FIX next edge.
  - RUN lasts exactly WIDTH cycles.
- FIX (one cycle):
  - {HI,LO} <= sign ? -product : product, in 2*WIDTH-bit two's complement.
  - Go to IDLE.
- Latency: accept edge at cycle 0; HI/LO hold the new value after edge WIDTH+1. busy_o is high for cycles 1..WIDTH+1 inclusive.
- flush_i while in RUN:
  - FSM returns to IDLE at the next edge; HI/LO are unchanged.
  - flush_i in FIX is ignored, because the write commits.
- flush_i in IDLE suppresses any request that cycle.
- MFHI/MFLO, not busy:
  - result_o <= HI (or LO) and result_valid_o <= 1 at the next edge.
  - A read issued in the cycle immediately after FIX returns the new value.
- MFHI/MFLO, busy: stall_o=1, no capture. The read completes in the first cycle busy_o is low.
- result_valid_o is a single-cycle pulse per accepted read and is 0 otherwise. result_o holds its last value.
- req_mult while busy: stalls. It is accepted the first cycle busy_o is low, which is back-to-back after FIX with no bubble.
- HI/LO are written only in FIX and by reset.

Test Plan:
- Reset, then 7*6 (a=7, b=6, code 8):
  - busy_o high for 33 cycles.
  - hi_o=0x00000000, lo_o=0x0000002A after edge 33.
  - Then MFLO gives result_o=0x2A with a one-cycle result_valid_o.
- -3*5 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1. 0x80000000*0x80000000 -> hi_o=0x40000000, lo_o=0x00000000.
- MFHI presented 1 cycle after a MULT accept:
  - stall_o=1 for 33 cycles, no result_valid_o pulse.
  - Then result_o=new HI in the cycle after busy_o falls; stall_o=0 for a non-multiply code (e.g. code 1) during busy.
- Load HI/LO=(0,42), start 100*100, assert flush_i at RUN cycle 10:
  - busy_o low next cycle.
  - hi_o/lo_o remain 0/42.
  - A following MULT 2*3 gives lo_o=6.
- Assert rst_n low mid-RUN (cycle 15) for 1 cycle -> busy_o=0, hi_o=lo_o=0, result_valid_o=0 immediately (asynchronous). The next MULT runs a full 33 cycles.
- Back-to-back MULTs (2*3 then 4*5 held with stall) -> second accepted the cycle after FIX, final lo_o=20. A flush_i pulse in FIX does not block the 2*3 write.

Source files
------------

// File: rtl/hilo_mult_unit_if.sv
// EX-stage bus between the pipeline and the HI/LO multiply unit.
// Carries the request, operands, flush, and all status/result returns.
interface hilo_mult_unit_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic [3:0]       alu_ctrl_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             stall_o;
    logic             busy_o;
    logic [WIDTH-1:0] result_o;
    logic             result_valid_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output valid_i, alu_ctrl_i, a_i, b_i, flush_i,
        input  stall_o, busy_o, result_o, result_valid_o, hi_o, lo_o
    );

    modport slave (
        input  valid_i, alu_ctrl_i, a_i, b_i, flush_i,
        output stall_o, busy_o, result_o, result_valid_o, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_mult_unit.sv
// Multi-cycle signed multiplier with HI/LO registers and MFHI/MFLO reads.
// Magnitudes are multiplied by radix-2 shift-add; sign is applied in FIX.
module hilo_mult_unit #(
    parameter int         WIDTH     = 32,
    parameter logic [3:0] CODE_MULT = 4'd8,
    parameter logic [3:0] CODE_MFLO = 4'd9,
    parameter logic [3:0] CODE_MFHI = 4'd10
) (
    input logic             clk,
    input logic             rst_n,
    hilo_mult_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   result_q;
    logic               rvalid_q;
    logic               busy_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               sign_q;

    logic               req_mult;
    logic               req_mfhi;
    logic               req_mflo;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum_d;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] prod_d;

    // Request decode, operand magnitudes, one shift-add step, signed product
    always_comb begin
        req_mult = bus.valid_i && (bus.alu_ctrl_i == CODE_MULT) && !bus.flush_i;
        req_mfhi = bus.valid_i && (bus.alu_ctrl_i == CODE_MFHI) && !bus.flush_i;
        req_mflo = bus.valid_i && (bus.alu_ctrl_i == CODE_MFLO) && !bus.flush_i;
        a_mag    = bus.a_i[WIDTH-1] ? -bus.a_i : bus.a_i;
        b_mag    = bus.b_i[WIDTH-1] ? -bus.b_i : bus.b_i;
        sum_d    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (mplier_q[0] ? mcand_q : '0)};
        acc_d    = {sum_d, acc_q[WIDTH-1:1]};
        prod_d   = sign_q ? -acc_q : acc_q;
    end

    assign bus.stall_o        = busy_q && (req_mult || req_mfhi || req_mflo);
    assign bus.busy_o         = busy_q;
    assign bus.result_o       = result_q;
    assign bus.result_valid_o = rvalid_q;
    assign bus.hi_o           = hi_q;
    assign bus.lo_o           = lo_q;

    // Control FSM with datapath registers; reads are served only in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_mult) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        sign_q   <= bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1];
                        acc_q    <= '0;
                        cnt_q    <= CW'(WIDTH);
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                    end else if (req_mfhi) begin
                        result_q <= hi_q;
                        rvalid_q <= 1'b1;
                    end else if (req_mflo) begin
                        result_q <= lo_q;
                        rvalid_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.flush_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q    <= acc_d;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q - 1'b1;
                        if (cnt_q == CW'(1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    hi_q    <= prod_d[2*WIDTH-1:WIDTH];
                    lo_q    <= prod_d[WIDTH-1:0];
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_mult_unit.sv
// Testbench for hilo_mult_unit: vector table, random products against
// a plain signed-multiply model, and hand-written stall/flush/reset cases.
module tb_hilo_mult_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hilo_mult_unit_if #(.WIDTH(W)) bus ();

    hilo_mult_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[6];
    int   total = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_prod(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[W-1]}}, a};
        sb = {{32{b[W-1]}}, b};
        return sa * sb;
    endfunction

    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                            output int cyc);
        bus.valid_i    = 1'b1;
        bus.alu_ctrl_i = 4'd8;
        bus.a_i        = a;
        bus.b_i        = b;
        #1;
        chk("mult_accept_stall", bus.stall_o, 0);
        tick();
        bus.valid_i = 1'b0;
        cyc = 0;
        while (bus.busy_o && cyc < 50) begin
            cyc++;
            tick();
        end
    endtask

    task automatic do_read(input logic [3:0] code, input logic [W-1:0] exp,
                           input string name);
        bus.valid_i    = 1'b1;
        bus.alu_ctrl_i = code;
        #1;
        chk({name, "_stall"}, bus.stall_o, 0);
        tick();
        chk({name, "_valid"}, bus.result_valid_o, 1);
        chk({name, "_data"}, bus.result_o, exp);
        bus.valid_i = 1'b0;
        tick();
        chk({name, "_pulse_end"}, bus.result_valid_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          n;
        int          rvs;
        logic [63:0] p;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{32'd7,        32'd6,        32'h0000_0000, 32'h0000_002A};
        vecs[1] = '{-32'sd3,      32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3] = '{32'd0,        32'h0001_2345, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};

        rst_n          = 1'b0;
        bus.valid_i    = 1'b0;
        bus.alu_ctrl_i = 4'd0;
        bus.a_i        = '0;
        bus.b_i        = '0;
        bus.flush_i    = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("rst_busy", bus.busy_o, 0);
        chk("rst_hi", bus.hi_o, 0);
        chk("rst_lo", bus.lo_o, 0);
        chk("rst_rvalid", bus.result_valid_o, 0);
        chk("rst_result", bus.result_o, 0);
        chk("rst_stall", bus.stall_o, 0);

        for (int i = 0; i < 6; i++) begin
            run_mult(vecs[i].a, vecs[i].b, cyc);
            chk("vec_busy_cycles", cyc, 33);
            chk("vec_hi", bus.hi_o, vecs[i].hi);
            chk("vec_lo", bus.lo_o, vecs[i].lo);
            do_read(4'd9, vecs[i].lo, "vec_mflo");
            do_read(4'd10, vecs[i].hi, "vec_mfhi");
        end

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) ra[W-1] = 1'b1;
            p = ref_prod(ra, rb);
            run_mult(ra, rb, cyc);
            chk("rnd_busy_cycles", cyc, 33);
            chk("rnd_hi", bus.hi_o, p[63:32]);
            chk("rnd_lo", bus.lo_o, p[31:0]);
            if (i % 4 == 0) do_read(4'd10, p[63:32], "rnd_mfhi");
        end

        bus.valid_i    = 1'b1;
        bus.alu_ctrl_i = 4'd8;
        bus.a_i        = -32'sd3;
        bus.b_i        = 32'd5;
        tick();
        bus.alu_ctrl_i = 4'd1;
        #1;
        chk("nonmul_busy", bus.busy_o, 1);
        chk("nonmul_no_stall", bus.stall_o, 0);
        bus.alu_ctrl_i = 4'd10;
        #1;
        n   = 0;
        rvs = 0;
        for (int k = 0; k < 50; k++) begin
            if (!bus.busy_o) break;
            if (bus.stall_o) n++;
            if (bus.result_valid_o) rvs++;
            tick();
        end
        chk("mfhi_busy_stall_cycles", n, 33);
        chk("mfhi_busy_no_pulse", rvs, 0);
        chk("mfhi_release_stall", bus.stall_o, 0);
        tick();
        chk("mfhi_after_busy_valid", bus.result_valid_o, 1);
        chk("mfhi_after_busy_data", bus.result_o, 32'hFFFF_FFFF);
        bus.valid_i = 1'b0;
        tick();
        chk("mfhi_after_busy_pulse_end", bus.result_valid_o, 0);

        run_mult(32'd6, 32'd7, cyc);
        chk("flush_pre_lo", bus.lo_o, 42);
        bus.valid_i    = 1'b1;
        bus.alu_ctrl_i = 4'd8;
        bus.a_i        = 32'd100;
        bus.b_i        = 32'd100;
        tick();
        bus.valid_i = 1'b0;
        repeat (9) tick();
        bus.flush_i = 1'b1;
        #1;
        chk("flush_busy_before", bus.busy_o, 1);
        tick();
        bus.flush_i = 1'b0;
        chk("flush_busy_after", bus.busy_o, 0);
        chk("flush_hi_kept", bus.hi_o, 0);
        chk("flush_lo_kept", bus.lo_o, 42);
        run_mult(32'd2, 32'd3, cyc);
        chk("flush_next_cycles", cyc, 33);
        chk("flush_next_lo", bus.lo_o, 6);

        bus.valid_i    = 1'b1;
        bus.alu_ctrl_i = 4'd8;
        bus.a_i        = 32'd9;
        bus.b_i        = 32'd9;
        tick();
        bus.valid_i = 1'b0;
        repeat (14) tick();
        chk("areset_busy_before", bus.busy_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_busy", bus.busy_o, 0);
        chk("areset_hi", bus.hi_o, 0);
        chk("areset_lo", bus.lo_o, 0);
        chk("areset_rvalid", bus.result_valid_o, 0);
        tick();
        rst_n = 1'b1;
        #1;
        run_mult(32'd3, 32'd4, cyc);
        chk("areset_next_cycles", cyc, 33);
        chk("areset_next_lo", bus.lo_o, 12);

        bus.valid_i    = 1'b1;
        bus.alu_ctrl_i = 4'd8;
        bus.a_i        = 32'd2;
        bus.b_i        = 32'd3;
        tick();
        bus.a_i = 32'd4;
        bus.b_i = 32'd5;
        n = 0;
        for (int k = 1; k <= 33; k++) begin
            bus.flush_i = (k == 33);
            #1;
            if (bus.busy_o && (bus.stall_o == (k != 33))) n++;
            tick();
        end
        bus.flush_i = 1'b0;
        #1;
        chk("b2b_stall_pattern", n, 33);
        chk("b2b_idle_gap", bus.busy_o, 0);
        chk("b2b_first_lo", bus.lo_o, 6);
        chk("b2b_no_stall_idle", bus.stall_o, 0);
        tick();
        chk("b2b_second_accepted", bus.busy_o, 1);
        bus.valid_i = 1'b0;
        cyc = 1;
        while (bus.busy_o && cyc < 50) begin
            tick();
            if (bus.busy_o) cyc++;
        end
        chk("b2b_second_cycles", cyc, 33);
        chk("b2b_second_lo", bus.lo_o, 20);
        chk("b2b_second_hi", bus.hi_o, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
